// File: rtl/slab_interval_sequencer.sv
// ---------------------------------------------------------------------------
// SlabIntervalSequencer (module slab_interval_sequencer)
//
// Purpose:
//   Front end of the Ray-AABB FP(11,23) slab test. One ray's three t_near
//   and three t_far slab distances are accepted and pushed through a single
//   shared, pipelined FloPoCo greater_or_equal comparator as six serial
//   comparisons. The results form
//       t_entry = max(tn0, tn1, tn2)
//       t_exit  = min(tf0, tf1, tf2)
//       hit     = (t_exit >= t_entry) && (t_exit >= +0)
//   and are returned over a valid/ready handshake.
//
// Parameters:
//   WIDTH   : MSB index of a FloPoCo word. Words are WIDTH+1 bits wide,
//             [WIDTH:WIDTH-1] = exception field, [WIDTH-2] = sign.
//   CMP_LAT : cycles from cmp_a/cmp_b being presented to cmp_result being
//             valid. Must match the comparator's FPSub depth plus its
//             output register.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : ray input handshake
//   tn0..tn2 / tf0..tf2   : per-axis t_near / t_far
//   cmp_a, cmp_b          : operands towards the shared comparator
//   cmp_result            : comparator answer, 1 iff cmp_a >= cmp_b
//   out_valid / out_ready : result handshake
//   hit, t_entry, t_exit  : result of the slab test
//   busy                  : a ray is in flight (state other than IDLE)
// ---------------------------------------------------------------------------
module slab_interval_sequencer #(
    parameter int WIDTH   = 36,
    parameter int CMP_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   tn0,
    input  logic [WIDTH:0]   tn1,
    input  logic [WIDTH:0]   tn2,
    input  logic [WIDTH:0]   tf0,
    input  logic [WIDTH:0]   tf1,
    input  logic [WIDTH:0]   tf2,
    output logic [WIDTH:0]   cmp_a,
    output logic [WIDTH:0]   cmp_b,
    input  logic             cmp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             hit,
    output logic [WIDTH:0]   t_entry,
    output logic [WIDTH:0]   t_exit,
    output logic             busy
);

    // The wait counter only has to reach CMP_LAT-1; it is cleared in ISSUE
    // and the first WAIT cycle therefore already counts as one elapsed cycle.
    localparam int               CNT_W    = (CMP_LAT > 1) ? $clog2(CMP_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMP_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } SeqState;

    SeqState          r_state;
    logic [WIDTH:0]   r_tn0;
    logic [WIDTH:0]   r_tn1;
    logic [WIDTH:0]   r_tn2;
    logic [WIDTH:0]   r_tf0;
    logic [WIDTH:0]   r_tf1;
    logic [WIDTH:0]   r_tf2;
    logic [WIDTH:0]   r_nMax;
    logic [WIDTH:0]   r_fMin;
    logic             r_r5;
    logic [2:0]       r_k;
    logic [CNT_W-1:0] r_waitCnt;

    logic             w_anyNan;
    logic             w_sampleNow;
    logic [WIDTH:0]   w_nMaxNext;
    logic [WIDTH:0]   w_fMinNext;
    logic [WIDTH:0]   w_nextA;
    logic [WIDTH:0]   w_nextB;

    // A FloPoCo word is NaN when its exception field is 2'b11. Infinities
    // (2'b10) are deliberately not trapped and go through the comparator.
    function automatic logic isNan(input logic [WIDTH:0] x);
        return (x[WIDTH:WIDTH-1] == 2'b11);
    endfunction

    // NaN screening is done on the live inputs in the acceptance cycle, so
    // a NaN ray can be answered on the very next cycle without touching the
    // comparator.
    always_comb begin
        w_anyNan = isNan(tn0) | isNan(tn1) | isNan(tn2) |
                   isNan(tf0) | isNan(tf1) | isNan(tf2);
    end

    // The comparator answer for comparison r_k is consumed on the last WAIT
    // cycle, once CMP_LAT cycles have passed since its operands appeared.
    always_comb begin
        w_sampleNow = (r_state == WAIT) && (r_waitCnt == CNT_LAST);
    end

    // Running max of t_near and running min of t_far as they would look
    // after folding in the current comparator answer. These are also what
    // the following comparison needs as its operand, so they are computed
    // combinationally and fed straight into the operand select below.
    always_comb begin
        w_nMaxNext = r_nMax;
        w_fMinNext = r_fMin;
        case (r_k)
            3'd1: w_nMaxNext = cmp_result ? r_tn1 : r_tn0;
            3'd2: if (cmp_result) w_nMaxNext = r_tn2;
            3'd3: w_fMinNext = cmp_result ? r_tf0 : r_tf1;
            3'd4: if (!cmp_result) w_fMinNext = r_tf2;
            default: ;
        endcase
    end

    // Operands for comparison r_k+1. They are registered on the same edge
    // that moves the FSM into ISSUE, so they are already on cmp_a/cmp_b
    // during the ISSUE cycle and stay put until their answer is sampled.
    // Comparison 6 checks t_exit against FloPoCo +0 (the all-zero word).
    always_comb begin
        w_nextA = cmp_a;
        w_nextB = cmp_b;
        case (r_k)
            3'd1: begin
                w_nextA = r_tn2;
                w_nextB = w_nMaxNext;
            end
            3'd2: begin
                w_nextA = r_tf1;
                w_nextB = r_tf0;
            end
            3'd3: begin
                w_nextA = r_tf2;
                w_nextB = w_fMinNext;
            end
            3'd4: begin
                w_nextA = w_fMinNext;
                w_nextB = r_nMax;
            end
            3'd5: begin
                w_nextA = r_fMin;
                w_nextB = '0;
            end
            default: ;
        endcase
    end

    // Main sequencer. All handshake and result outputs are registered here.
    // IDLE latches the ray, ISSUE/WAIT walk the six comparisons, DONE holds
    // the result until the downstream side takes it. cmp_a/cmp_b are only
    // written when a comparison is launched, so they keep their last value
    // in IDLE and DONE. An asynchronous reset abandons any ray in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            hit       <= 1'b0;
            t_entry   <= '0;
            t_exit    <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            r_tn0     <= '0;
            r_tn1     <= '0;
            r_tn2     <= '0;
            r_tf0     <= '0;
            r_tf1     <= '0;
            r_tf2     <= '0;
            r_nMax    <= '0;
            r_fMin    <= '0;
            r_r5      <= 1'b0;
            r_k       <= 3'd1;
            r_waitCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_tn0    <= tn0;
                        r_tn1    <= tn1;
                        r_tn2    <= tn2;
                        r_tf0    <= tf0;
                        r_tf1    <= tf1;
                        r_tf2    <= tf2;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (w_anyNan) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                            hit       <= 1'b0;
                            t_entry   <= tn0;
                            t_exit    <= tf0;
                        end else begin
                            r_state <= ISSUE;
                            r_k     <= 3'd1;
                            cmp_a   <= tn1;
                            cmp_b   <= tn0;
                        end
                    end
                end

                ISSUE: begin
                    r_waitCnt <= '0;
                    r_state   <= WAIT;
                end

                WAIT: begin
                    if (w_sampleNow) begin
                        r_nMax <= w_nMaxNext;
                        r_fMin <= w_fMinNext;
                        if (r_k == 3'd5) begin
                            r_r5 <= cmp_result;
                        end
                        if (r_k == 3'd6) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                            hit       <= r_r5 & cmp_result;
                            t_entry   <= r_nMax;
                            t_exit    <= r_fMin;
                        end else begin
                            r_state <= ISSUE;
                            r_k     <= r_k + 3'd1;
                            cmp_a   <= w_nextA;
                            cmp_b   <= w_nextB;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
